nfc_command_program_page: RTL

- Command-layer FSM for ONFI PAGE PROGRAM: 80h, 5 address cycles, data-in burst, 10h, then wait for R/B# busy then ready.
- Write-direction counterpart of the page-read command block. Sits between the command dispatcher and the atom command generator (ACG) on the shared ACG bus.
- Drives CAL atom (ACG bit 3) for command/address and DOA atom (ACG bit 5) for the write burst.
- Streams host write data to the ACG with a valid/ready handshake.

---
 rtl/nfc_cmd_pkg.sv | 36 +++
 rtl/nfc_command_program_page_if.sv | 30 +++
 rtl/nfc_rb_sync.sv | 30 +++
 rtl/nfc_command_program_page.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/nfc_cmd_pkg.sv
// rtl/nfc_cmd_pkg.sv - shared ACG atom indices, ONFI opcodes and address packing for NFC command blocks
package nfc_cmd_pkg;

  localparam int ACG_DIS = 1;
  localparam int ACG_CAL = 3;
  localparam int ACG_DOA = 5;

  localparam logic [7:0] ACG_SEL_CAL = 8'b1 << ACG_CAL;
  localparam logic [7:0] ACG_SEL_DOA = 8'b1 << ACG_DOA;

  localparam logic [7:0] ONFI_PROG_1 = 8'h80;
  localparam logic [7:0] ONFI_PROG_2 = 8'h10;
  localparam logic [7:0] ONFI_READ_1 = 8'h00;
  localparam logic [7:0] ONFI_READ_2 = 8'h30;

  localparam logic [6:0] ACG_READY_MASK = 7'h7F;

  typedef enum logic [9:0] {
    S_RESET        = 10'h001,
    S_READY        = 10'h002,
    S_CMD_LATCH    = 10'h004,
    S_CMD1         = 10'h008,
    S_ADDR         = 10'h010,
    S_DATA         = 10'h020,
    S_CMD2         = 10'h040,
    S_WAIT_RB_LOW  = 10'h080,
    S_WAIT_RB_HIGH = 10'h100,
    S_DONE         = 10'h200
  } pp_state_e;

  // Five address cycles, low column byte goes out on the bus first.
  function automatic logic [39:0] pack_addr(input logic [15:0] col, input logic [23:0] row);
    return {col[7:0], col[15:8], row[7:0], row[15:8], row[23:16]};
  endfunction

endpackage

// File: rtl/nfc_command_program_page_if.sv
// rtl/nfc_command_program_page_if.sv - shared ACG bus between a command block and the atom command generator
interface nfc_command_program_page_if #(
  parameter int NumberOfWays = 4
);
  logic [7:0]              oACG_Command;
  logic [2:0]              oACG_CommandOption;
  logic [7:0]              iACG_Ready;
  logic [7:0]              iACG_LastStep;
  logic [NumberOfWays-1:0] oACG_TargetWay;
  logic [15:0]             oACG_NumOfData;
  logic                    oACG_CASelect;
  logic [39:0]             oACG_CAData;
  logic [15:0]             oACG_WriteData;
  logic                    oACG_WriteLast;
  logic                    oACG_WriteValid;
  logic                    iACG_WriteReady;
  logic [NumberOfWays-1:0] iACG_ReadyBusy;

  modport master (
    output oACG_Command, oACG_CommandOption, oACG_TargetWay, oACG_NumOfData,
           oACG_CASelect, oACG_CAData, oACG_WriteData, oACG_WriteLast, oACG_WriteValid,
    input  iACG_Ready, iACG_LastStep, iACG_WriteReady, iACG_ReadyBusy
  );

  modport slave (
    input  oACG_Command, oACG_CommandOption, oACG_TargetWay, oACG_NumOfData,
           oACG_CASelect, oACG_CAData, oACG_WriteData, oACG_WriteLast, oACG_WriteValid,
    output iACG_Ready, iACG_LastStep, iACG_WriteReady, iACG_ReadyBusy
  );
endinterface

// File: rtl/nfc_rb_sync.sv
// rtl/nfc_rb_sync.sv - way-masked two-flop R/B# synchronizer with OR reduce (1 = ready)
module nfc_rb_sync #(
  parameter int WAYS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [WAYS-1:0] way_mask,
  input  logic [WAYS-1:0] ready_busy,
  output logic            way_rb
);
  logic [WAYS-1:0] rb_q, rb_d;
  logic            way_rb_q, way_rb_d;

  always_comb begin
    rb_d     = way_mask & ready_busy;
    way_rb_d = |rb_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb_q     <= '0;
      way_rb_q <= 1'b0;
    end else begin
      rb_q     <= rb_d;
      way_rb_q <= way_rb_d;
    end
  end

  assign way_rb = way_rb_q;
endmodule

// File: rtl/nfc_command_program_page.sv
// rtl/nfc_command_program_page.sv - ONFI PAGE PROGRAM command FSM (80h, 5 addr, data burst, 10h, R/B# wait)
module nfc_command_program_page
  import nfc_cmd_pkg::*;
#(
  parameter int          NumberOfWays = 4,
  parameter logic [5:0]  CommandID    = 6'b000110,
  parameter logic [4:0]  TargetID     = 5'b00101,
  parameter logic [15:0] RBLowTimeout = 16'd64
) (
  input  logic                    iSystemClock,
  input  logic                    iReset,
  input  logic [5:0]              iOpcode,
  input  logic [4:0]              iTargetID,
  input  logic [15:0]             iLength,
  input  logic                    iCMDValid,
  output logic                    oCMDReady,
  input  logic [NumberOfWays-1:0] iWaySelect,
  input  logic [15:0]             iColAddress,
  input  logic [23:0]             iRowAddress,
  output logic                    oStart,
  output logic                    oLastStep,
  input  logic [15:0]             iWriteData,
  input  logic                    iWriteLast,
  input  logic                    iWriteValid,
  output logic                    oWriteReady,
  nfc_command_program_page_if.master acg
);
  pp_state_e               state_q, state_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    last_step_q, last_step_d;
  logic [7:0]              command_q, command_d;
  logic [NumberOfWays-1:0] target_way_q, target_way_d;
  logic [15:0]             num_data_q, num_data_d;
  logic                    ca_sel_q, ca_sel_d;
  logic [39:0]             ca_data_q, ca_data_d;
  logic [15:0]             length_q, length_d;
  logic [15:0]             col_q, col_d;
  logic [23:0]             row_q, row_d;
  logic [15:0]             tmo_cnt_q, tmo_cnt_d;
  logic                    way_rb, cal_done, doa_done, in_data;
  logic                    unused_ok;

  assign cal_done = acg.iACG_LastStep[ACG_CAL];
  assign doa_done = acg.iACG_LastStep[ACG_DOA];
  assign in_data  = (state_q == S_DATA);
  assign oStart   = (iOpcode == CommandID) && iCMDValid;

  nfc_rb_sync #(.WAYS(NumberOfWays)) u_rb_sync (
    .clk        (iSystemClock),
    .rst        (iReset),
    .way_mask   (target_way_q),
    .ready_busy (acg.iACG_ReadyBusy),
    .way_rb     (way_rb)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:        state_d = S_READY;
      S_READY:        if (oStart) state_d = S_CMD_LATCH;
      S_CMD_LATCH:    state_d = S_CMD1;
      S_CMD1:         if (cal_done) state_d = S_ADDR;
      S_ADDR:         if (cal_done) state_d = S_DATA;
      S_DATA:         if (doa_done) state_d = S_CMD2;
      S_CMD2:         if (cal_done) state_d = S_WAIT_RB_LOW;
      // A missed busy pulse falls through on timeout to the same wait-for-ready state.
      S_WAIT_RB_LOW:  if (!way_rb || (tmo_cnt_q == RBLowTimeout - 16'd1)) state_d = S_WAIT_RB_HIGH;
      S_WAIT_RB_HIGH: if (way_rb) state_d = S_DONE;
      S_DONE:         state_d = S_READY;
      default:        state_d = S_RESET;
    endcase
  end

  always_comb begin
    cmd_ready_d  = (state_d == S_READY);
    last_step_d  = (state_d == S_DONE);
    target_way_d = (state_q == S_READY) ? iWaySelect : target_way_q;
    length_d     = (state_q == S_CMD_LATCH) ? iLength     : length_q;
    col_d        = (state_q == S_CMD_LATCH) ? iColAddress : col_q;
    row_d        = (state_q == S_CMD_LATCH) ? iRowAddress : row_q;
    tmo_cnt_d    = (state_q == S_WAIT_RB_LOW) ? tmo_cnt_q + 16'd1 : 16'd0;
    command_d    = 8'h00;
    ca_sel_d     = ca_sel_q;
    ca_data_d    = ca_data_q;
    num_data_d   = num_data_q;
    // Atom outputs are decoded from the next state so they appear with the state itself.
    case (state_d)
      S_READY: begin
        ca_sel_d   = 1'b1;
        ca_data_d  = 40'h0;
        num_data_d = 16'd0;
      end
      S_CMD1: begin
        command_d  = ACG_SEL_CAL;
        ca_sel_d   = 1'b1;
        ca_data_d  = {ONFI_PROG_1, 32'h0};
        num_data_d = 16'd0;
      end
      S_ADDR: begin
        command_d  = ACG_SEL_CAL;
        ca_sel_d   = 1'b0;
        ca_data_d  = pack_addr(col_q, row_q);
        num_data_d = 16'd4;
      end
      S_DATA: begin
        command_d  = ACG_SEL_DOA;
        ca_sel_d   = 1'b0;
        num_data_d = length_q;
      end
      S_CMD2: begin
        command_d  = ACG_SEL_CAL;
        ca_sel_d   = 1'b1;
        ca_data_d  = {ONFI_PROG_2, 32'h0};
        num_data_d = 16'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iSystemClock or posedge iReset) begin
    if (iReset) begin
      state_q      <= S_RESET;
      cmd_ready_q  <= 1'b1;
      last_step_q  <= 1'b0;
      command_q    <= 8'h00;
      target_way_q <= '0;
      num_data_q   <= 16'd0;
      ca_sel_q     <= 1'b1;
      ca_data_q    <= 40'h0;
      length_q     <= 16'd0;
      col_q        <= 16'd0;
      row_q        <= 24'd0;
      tmo_cnt_q    <= 16'd0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      last_step_q  <= last_step_d;
      command_q    <= command_d;
      target_way_q <= target_way_d;
      num_data_q   <= num_data_d;
      ca_sel_q     <= ca_sel_d;
      ca_data_q    <= ca_data_d;
      length_q     <= length_d;
      col_q        <= col_d;
      row_q        <= row_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  assign oCMDReady              = cmd_ready_q;
  assign oLastStep              = last_step_q;
  assign acg.oACG_Command       = command_q;
  assign acg.oACG_CommandOption = 3'b000;
  assign acg.oACG_TargetWay     = target_way_q;
  assign acg.oACG_NumOfData     = num_data_q;
  assign acg.oACG_CASelect      = ca_sel_q;
  assign acg.oACG_CAData        = ca_data_q;
  assign acg.oACG_WriteData     = iWriteData;
  assign acg.oACG_WriteLast     = iWriteLast;
  assign acg.oACG_WriteValid    = iWriteValid & in_data;
  assign oWriteReady            = acg.iACG_WriteReady & in_data;

  assign unused_ok = ^{iTargetID, TargetID, acg.iACG_Ready, acg.iACG_LastStep[7:6],
                       acg.iACG_LastStep[4], acg.iACG_LastStep[2:0]};
endmodule
